// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// An operation latches its operands at start and writes HI/LO only at completion.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [1:0]  op_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic [63:0] prodS;
    logic [63:0] prodU;
    logic        negA;
    logic        negB;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [31:0] magQ;
    logic [31:0] magR;
    logic [31:0] divisorU;
    logic [31:0] resHi_d;
    logic [31:0] resLo_d;

    // Signed division works on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 with no special case.
    always_comb begin
        prodS    = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prodU    = {32'd0, a_q} * {32'd0, b_q};
        negA     = a_q[31];
        negB     = b_q[31];
        absA     = negA ? (32'd0 - a_q) : a_q;
        absB     = negB ? (32'd0 - b_q) : b_q;
        divisorU = (b_q == 32'd0) ? 32'd1 : b_q;
        if (absB == 32'd0) begin
            magQ = 32'd0;
            magR = 32'd0;
        end else begin
            magQ = absA / absB;
            magR = absA % absB;
        end
        resHi_d = 32'd0;
        resLo_d = 32'd0;
        case (op_q)
            2'b00: begin
                resHi_d = prodS[63:32];
                resLo_d = prodS[31:0];
            end
            2'b01: begin
                resHi_d = prodU[63:32];
                resLo_d = prodU[31:0];
            end
            2'b10: begin
                resLo_d = (negA ^ negB) ? (32'd0 - magQ) : magQ;
                resHi_d = negA ? (32'd0 - magR) : magR;
            end
            default: begin
                resLo_d = a_q / divisorU;
                resHi_d = a_q % divisorU;
            end
        endcase
    end

    // Moves to HI/LO are only honoured in IDLE without a competing start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'b00;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= src_a;
                        b_q     <= src_b;
                        op_q    <= op;
                        cnt_q   <= op[1] ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
                        state_q <= RUN;
                    end else begin
                        if (mthi) hi_q <= src_a;
                        if (mtlo) lo_q <= src_a;
                    end
                end
                RUN: begin
                    if (cnt_q <= 32'd1) begin
                        cnt_q   <= 32'd0;
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        if (!(op_q[1] && (b_q == 32'd0))) begin
                            hi_q <= resHi_d;
                            lo_q <= resLo_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
